// File: rtl/exec_perm_check.sv
// Instruction-fetch permission checker.
// Each fetch port is checked against the page NX bit and, when SMEP is on,
// against supervisor fetches from user pages. Per-port faults are registered
// with one cycle of latency. The first fault is held for the trap logic until
// it is acknowledged. The block also detects overrun and keeps a saturating
// fault count.

// Per-port fault decode. This block is purely combinational.
module exec_perm_lane (
    input  logic       valid_i,
    input  logic       nx_en_i,
    input  logic       smep_en_i,
    input  logic       cpu_user_i,
    input  logic       nx_flag_i,
    input  logic       user_page_i,
    output logic [1:0] cause_o,
    output logic       hit_o
);
    logic w_nx_hit;
    logic w_smep_hit;

    assign w_nx_hit   = valid_i & nx_en_i & nx_flag_i;
    assign w_smep_hit = valid_i & smep_en_i & ~cpu_user_i & user_page_i;
    assign cause_o    = {w_smep_hit, w_nx_hit};
    assign hit_o      = w_nx_hit | w_smep_hit;
endmodule

module exec_perm_check #(
    parameter int NUM_PORTS = 2,
    parameter int VA_WIDTH  = 64,
    parameter int CNT_WIDTH = 16,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            nx_en_i,
    input  logic                            smep_en_i,
    input  logic                            cpu_user_i,
    input  logic [NUM_PORTS-1:0]            fetch_valid_i,
    input  logic [NUM_PORTS*VA_WIDTH-1:0]   fetch_addr_i,
    input  logic [NUM_PORTS-1:0]            nx_flag_i,
    input  logic [NUM_PORTS-1:0]            user_page_i,
    output logic [NUM_PORTS-1:0]            fault_o,
    output logic [2*NUM_PORTS-1:0]          fault_cause_o,
    output logic                            cap_valid_o,
    output logic [VA_WIDTH-1:0]             cap_addr_o,
    output logic [PW-1:0]                   cap_port_o,
    output logic [1:0]                      cap_cause_o,
    output logic                            cap_overrun_o,
    input  logic                            fault_ack_i,
    output logic [CNT_WIDTH-1:0]            fault_count_o
);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_HELD = 1'b1;
    localparam int   SW     = CNT_WIDTH + 4;  // headroom for adding up to 8 hits

    logic [2*NUM_PORTS-1:0] w_cause;
    logic [NUM_PORTS-1:0]   w_hit;
    logic                   w_any_hit;
    logic [PW-1:0]          w_sel_idx;
    logic [VA_WIDTH-1:0]    w_sel_addr;
    logic [1:0]             w_sel_cause;
    logic                   w_sel_found;
    logic [3:0]             w_pop;
    logic [SW-1:0]          w_cnt_sum;
    logic [CNT_WIDTH-1:0]   w_cnt_next;

    logic                   r_state;
    logic [NUM_PORTS-1:0]   r_fault;
    logic [2*NUM_PORTS-1:0] r_cause;
    logic [VA_WIDTH-1:0]    r_cap_addr;
    logic [PW-1:0]          r_cap_port;
    logic [1:0]             r_cap_cause;
    logic                   r_overrun;
    logic [CNT_WIDTH-1:0]   r_count;

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_lane
            exec_perm_lane u_lane (
                .valid_i     (fetch_valid_i[gp]),
                .nx_en_i     (nx_en_i),
                .smep_en_i   (smep_en_i),
                .cpu_user_i  (cpu_user_i),
                .nx_flag_i   (nx_flag_i[gp]),
                .user_page_i (user_page_i[gp]),
                .cause_o     (w_cause[2*gp +: 2]),
                .hit_o       (w_hit[gp])
            );
        end
    endgenerate

    assign w_any_hit = |w_hit;

    // Select the lowest-indexed hitting port for capture.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_addr  = '0;
        w_sel_cause = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_hit[p] && !w_sel_found) begin
                w_sel_found = 1'b1;
                w_sel_idx   = PW'(p);
                w_sel_addr  = fetch_addr_i[p*VA_WIDTH +: VA_WIDTH];
                w_sel_cause = w_cause[2*p +: 2];
            end
        end
    end

    // Add this cycle's hit count and saturate at the counter's maximum value.
    always_comb begin
        w_pop = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_pop = w_pop + 4'(w_hit[p]);
        end
        w_cnt_sum = SW'(r_count) + SW'(w_pop);
        if (w_cnt_sum > SW'({CNT_WIDTH{1'b1}}))
            w_cnt_next = {CNT_WIDTH{1'b1}};
        else
            w_cnt_next = w_cnt_sum[CNT_WIDTH-1:0];
    end

    // Register the per-port faults and the counter. Run the capture FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_fault     <= '0;
            r_cause     <= '0;
            r_cap_addr  <= '0;
            r_cap_port  <= '0;
            r_cap_cause <= '0;
            r_overrun   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_fault <= w_hit;
            r_cause <= w_cause;
            r_count <= w_cnt_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any_hit) begin
                        r_cap_addr  <= w_sel_addr;
                        r_cap_port  <= w_sel_idx;
                        r_cap_cause <= w_sel_cause;
                        r_state     <= S_HELD;
                    end
                end
                default: begin
                    if (fault_ack_i) begin
                        // When an ack and a new hit arrive together, the new
                        // fault replaces the old one, so the new fault is
                        // not lost.
                        r_overrun <= 1'b0;
                        if (w_any_hit) begin
                            r_cap_addr  <= w_sel_addr;
                            r_cap_port  <= w_sel_idx;
                            r_cap_cause <= w_sel_cause;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_any_hit) begin
                        r_overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign fault_o       = r_fault;
    assign fault_cause_o = r_cause;
    assign cap_valid_o   = (r_state == S_HELD);
    assign cap_addr_o    = r_cap_addr;
    assign cap_port_o    = r_cap_port;
    assign cap_cause_o   = r_cap_cause;
    assign cap_overrun_o = r_overrun;
    assign fault_count_o = r_count;
endmodule

// File: tb/tb_exec_perm_check.sv
// Self-checking bench for exec_perm_check.
// The DUT uses 2 ports, 64-bit addresses and a 4-bit counter, so the
// saturation case is quick to reach.
module tb_exec_perm_check;
    localparam int NP = 2;
    localparam int VW = 64;
    localparam int CW = 4;

    typedef struct packed {
        logic [1:0]  fault;
        logic [3:0]  cause;
        logic        cv;
        logic [63:0] addr;
        logic [0:0]  port;
        logic [1:0]  ccause;
        logic        ovr;
        logic [3:0]  cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            nx_en = 1'b0, smep_en = 1'b0, cpu_user = 1'b0, ack = 1'b0;
    logic [NP-1:0]   valid = '0, nx = '0, upage = '0;
    logic [NP*VW-1:0] addr = '0;
    logic [NP-1:0]   fault_o;
    logic [2*NP-1:0] fault_cause_o;
    logic            cap_valid_o, cap_overrun_o;
    logic [VW-1:0]   cap_addr_o;
    logic [0:0]      cap_port_o;
    logic [1:0]      cap_cause_o;
    logic [CW-1:0]   fault_count_o;

    exp_t obs, e;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    assign obs = {fault_o, fault_cause_o, cap_valid_o, cap_addr_o, cap_port_o,
                  cap_cause_o, cap_overrun_o, fault_count_o};

    exec_perm_check #(.NUM_PORTS(NP), .VA_WIDTH(VW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .nx_en_i(nx_en), .smep_en_i(smep_en),
        .cpu_user_i(cpu_user), .fetch_valid_i(valid), .fetch_addr_i(addr),
        .nx_flag_i(nx), .user_page_i(upage), .fault_o(fault_o),
        .fault_cause_o(fault_cause_o), .cap_valid_o(cap_valid_o),
        .cap_addr_o(cap_addr_o), .cap_port_o(cap_port_o),
        .cap_cause_o(cap_cause_o), .cap_overrun_o(cap_overrun_o),
        .fault_ack_i(ack), .fault_count_o(fault_count_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [1:0] f, logic [3:0] c, logic cv,
                                logic [63:0] a, logic [0:0] p, logic [1:0] cc,
                                logic o, logic [3:0] n);
        exp_t r;
        r = '{fault: f, cause: c, cv: cv, addr: a, port: p, ccause: cc, ovr: o, cnt: n};
        return r;
    endfunction

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        nx_en = 0; smep_en = 0; cpu_user = 0; ack = 0;
        valid = '0; nx = '0; upage = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        // NX hits are driven during reset. They must be ignored.
        nx_en = 1; valid = 2'b11; nx = 2'b11; rst = 1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reset got=%h exp=%h", obs, e); end
        rst = 0; idle_inputs();
    endtask

    task automatic test_nx_single();
        do_reset();
        nx_en = 1; valid = 2'b01; nx = 2'b01; addr[0 +: 64] = 64'h0000_7FFF_0000_1000;
        sb.push_back(mk(2'b01, 4'b0001, 1, 64'h0000_7FFF_0000_1000, 0, 2'b01, 0, 1));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL nx_single got=%h exp=%h", obs, e); end
        idle_inputs();
        sb.push_back(mk(2'b00, 4'b0000, 1, 64'h0000_7FFF_0000_1000, 0, 2'b01, 0, 1));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL nx_hold got=%h exp=%h", obs, e); end
    endtask

    task automatic test_smep();
        do_reset();
        smep_en = 1; cpu_user = 0; upage = 2'b01; valid = 2'b01;
        addr[0 +: 64] = 64'h0000_0000_0040_2000;
        sb.push_back(mk(2'b01, 4'b0010, 1, 64'h0000_0000_0040_2000, 0, 2'b10, 0, 1));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL smep_sup got=%h exp=%h", obs, e); end
        cpu_user = 1;
        sb.push_back(mk(2'b00, 4'b0000, 1, 64'h0000_0000_0040_2000, 0, 2'b10, 0, 1));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL smep_user got=%h exp=%h", obs, e); end
        // A combined NX and SMEP hit while HELD gives cause 11 and sets overrun.
        cpu_user = 0; nx_en = 1; nx = 2'b01;
        sb.push_back(mk(2'b01, 4'b0011, 1, 64'h0000_0000_0040_2000, 0, 2'b10, 1, 2));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL smep_both got=%h exp=%h", obs, e); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        nx_en = 1; valid = 2'b11; nx = 2'b11;
        addr[0 +: 64] = 64'h0000_0000_0000_B000; addr[64 +: 64] = 64'h0000_0000_0000_B100;
        sb.push_back(mk(2'b11, 4'b0101, 1, 64'h0000_0000_0000_B000, 0, 2'b01, 0, 2));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL simultaneous got=%h exp=%h", obs, e); end
    endtask

    task automatic test_overrun_ack();
        // Starts in HELD with the port 0 capture from test_simultaneous, count 2.
        valid = 2'b10; nx = 2'b10; addr[64 +: 64] = 64'h0000_0000_0000_C100;
        sb.push_back(mk(2'b10, 4'b0100, 1, 64'h0000_0000_0000_B000, 0, 2'b01, 1, 3));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL overrun got=%h exp=%h", obs, e); end
        ack = 1; addr[64 +: 64] = 64'h0000_0000_0000_D100;
        sb.push_back(mk(2'b10, 4'b0100, 1, 64'h0000_0000_0000_D100, 1, 2'b01, 0, 4));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL ack_race got=%h exp=%h", obs, e); end
        valid = '0; nx = '0;
        sb.push_back(mk(2'b00, 4'b0000, 0, 64'h0000_0000_0000_D100, 1, 2'b01, 0, 4));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL ack_alone got=%h exp=%h", obs, e); end
        // An ack in IDLE has no effect.
        sb.push_back(mk(2'b00, 4'b0000, 0, 64'h0000_0000_0000_D100, 1, 2'b01, 0, 4));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL ack_idle got=%h exp=%h", obs, e); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        nx_en = 1; valid = 2'b01; nx = 2'b01; addr[0 +: 64] = 64'h0000_0000_0000_E000;
        for (int i = 0; i < 20; i++) begin
            sb.push_back(mk(2'b01, 4'b0001, 1, 64'h0000_0000_0000_E000, 0, 2'b01,
                            (i >= 1), (i + 1 > 15) ? 4'd15 : 4'(i + 1)));
            step();
            e = sb.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL sat1 cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        valid = '0; nx = '0; ack = 1;
        sb.push_back(mk(2'b00, 4'b0000, 0, 64'h0000_0000_0000_E000, 0, 2'b01, 0, 15));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL sat_ack got=%h exp=%h", obs, e); end
        // Two hits per cycle: 14 + 2 must clamp to 15 and not wrap.
        do_reset();
        nx_en = 1; valid = 2'b11; nx = 2'b11;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(mk(2'b11, 4'b0101, 1, 64'h0000_0000_0000_E000, 0, 2'b01,
                            (i >= 1), (2 * (i + 1) > 15) ? 4'd15 : 4'(2 * (i + 1))));
            step();
            e = sb.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL sat2 cyc=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_reset_held();
        // Starts in HELD with overrun set. Reset discards the capture, and
        // hits during the reset cycle are ignored.
        rst = 1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        e = sb.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_held got=%h exp=%h", obs, e); end
        rst = 0; nx_en = 0; smep_en = 0; cpu_user = 0; upage = 2'b11;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
            step();
            e = sb.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL nx_disabled cyc=%0d got=%h exp=%h", i, obs, e); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_nx_single();
        test_smep();
        test_simultaneous();
        test_overrun_ack();
        test_saturation();
        test_reset_held();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
